// File: rtl/bitrev_result_drain.sv
// bitrev_result_drain
//   Pulls a job's result words out of the bit-reversal accelerator and streams
//   them to the bus side. After arm_i the block waits for done_flag_i. It then
//   issues read_o pulses and captures each returned word READ_LAT cycles later
//   into a small FIFO. A valid/ready stream drains the FIFO.
//
// Ports
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   arm_i, len_i     start pulse and job length (1..MAX_WORDS, else ignored)
//   done_flag_i      accelerator results ready (level)
//   dout_i, read_o   accelerator result word / read request pulse
//   m_tdata_o, m_tvalid_o, m_tready_i, m_tlast_o   output stream
//   busy_o           a job is in progress (FSM not idle)
//   job_done_o       pulse when the job's last word is popped
//   dbg_state_o      current FSM state, for observation only
//
// Stream handshake: a word transfers in every cycle where m_tvalid_o and
// m_tready_i are both 1. Once m_tvalid_o rises it stays high, and m_tdata_o and
// m_tlast_o hold steady, until that transfer happens.
module bitrev_result_drain #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           arm_i,
    input  logic [$clog2(MAX_WORDS+1)-1:0] len_i,
    input  logic                           done_flag_i,
    input  logic [DATA_W-1:0]              dout_i,
    output logic                           read_o,
    output logic [DATA_W-1:0]              m_tdata_o,
    output logic                           m_tvalid_o,
    input  logic                           m_tready_i,
    output logic                           m_tlast_o,
    output logic                           busy_o,
    output logic                           job_done_o,
    output logic [1:0]                     dbg_state_o
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_DRAIN     = 2'd2,
        S_FLUSH     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_len;
    logic [CW-1:0]       r_issued;
    logic [CW-1:0]       r_cap_idx;
    logic [READ_LAT-1:0] r_pipe;
    logic [FW-1:0]       r_inflight;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [FW-1:0]       r_count;
    logic [DATA_W-1:0]   r_mem  [DEPTH];
    logic                r_last [DEPTH];

    logic                w_arm_accept;
    logic                w_read;
    logic                w_capture;
    logic                w_valid;
    logic                w_pop;
    logic                w_last_pop;
    logic                w_job_done;
    logic [FW:0]         w_credit;

    assign w_arm_accept = (r_state == S_IDLE) && arm_i &&
                          (len_i != '0) && (len_i <= CW'(MAX_WORDS));

    // Words already stored plus words still in the latency pipe. Reading only
    // while this is below DEPTH guarantees every capture finds a free slot.
    assign w_credit   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_read     = (r_state == S_DRAIN) && (r_issued < r_len) &&
                        (w_credit < (FW+1)'(DEPTH));
    assign w_capture  = r_pipe[READ_LAT-1];
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && m_tready_i;
    assign w_last_pop = w_pop && r_last[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_job_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm_accept) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_flag_i) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_read && ((r_issued + CW'(1)) == r_len)) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if ((r_inflight == '0) && w_last_pop) begin
                    w_state_nxt = S_IDLE;
                    w_job_done  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_cap_idx  <= '0;
            r_pipe     <= '0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_arm_accept) begin
                r_len     <= len_i;
                r_issued  <= '0;
                r_cap_idx <= '0;
            end else begin
                if (w_read)    r_issued  <= r_issued + CW'(1);
                if (w_capture) r_cap_idx <= r_cap_idx + CW'(1);
            end

            // Valid shift pipe: a 1 emerges at the top exactly when the
            // matching word is present on dout_i.
            r_pipe[0] <= w_read;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_inflight <= r_inflight + FW'(w_read) - FW'(w_capture);

            if (w_capture) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);

            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + FW'(1);
                2'b01:   r_count <= r_count - FW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the count gates everything read out of it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr]  <= dout_i;
            r_last[r_wr_ptr] <= (r_cap_idx == (r_len - CW'(1)));
        end
    end

    assign read_o      = w_read;
    assign m_tvalid_o  = w_valid;
    assign m_tdata_o   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign m_tlast_o   = w_valid && r_last[r_rd_ptr];
    assign busy_o      = (r_state != S_IDLE);
    assign job_done_o  = w_job_done;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bitrev_result_drain.sv
// Bench for bitrev_result_drain. The bench models the accelerator as a
// READ_LAT-deep delay line of read indices. A reference queue holds the
// words the stream should carry, tagged with the last-word flag. The
// expected read_o follows the credit rule applied to the model's own
// occupancy.
module tb_bitrev_result_drain;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int MAXW  = 16;
  localparam int RL    = 3;
  localparam int LW    = $clog2(MAXW + 1);

  // clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          done_flag_i = 1'b0;
  logic [DW-1:0] dout_i = '0;
  logic          m_tready_i = 1'b0;
  logic          read_o, m_tvalid_o, m_tlast_o, busy_o, job_done_o;
  logic [DW-1:0] m_tdata_o;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  bitrev_result_drain #(
    .DATA_W(DW), .DEPTH(DEPTH), .MAX_WORDS(MAXW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .arm_i(arm_i), .len_i(len_i),
    .done_flag_i(done_flag_i), .dout_i(dout_i), .read_o(read_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .busy_o(busy_o), .job_done_o(job_done_o),
    .dbg_state_o(dbg_state)
  );

  // scoreboard / model state
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW:0]   exp_q[$];     // {last, data}
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] job_words [MAXW];
  int            dq[$];        // read index per latency slot, -1 = none
  int            phase = 0;    // 0 idle, 1 waiting for done, 2 draining
  int            job_len = 0;
  int            reads_issued = 0;
  int            word_base = -1;
  int            tready_mode = 1; // 0 low, 1 high, 2 random
  int            cyc = 0;
  int            rd_total = 0;
  int            first_rd_cyc = -1;
  int            last_rd_cyc = -1;
  int            jd_count = 0;
  int            done_cyc = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    dq.delete();
    for (int i = 0; i < RL; i++) dq.push_back(-1);
    phase = 0;
    reads_issued = 0;
  endtask

  // One clock cycle. Entered just after a rising edge; drives inputs, samples
  // and checks outputs, advances the model, then waits for the next edge.
  task automatic step();
    int   head, infl, idx;
    logic exp_rd, pop, exp_jd;
    logic [DW:0] hd;
    head = dq[0];
    case (tready_mode)
      0:       m_tready_i = 1'b0;
      1:       m_tready_i = 1'b1;
      default: m_tready_i = 1'($urandom_range(0, 1));
    endcase
    dout_i = (head >= 0) ? job_words[head] : $urandom();
    #1;
    infl = 0;
    foreach (dq[i]) if (dq[i] >= 0) infl++;
    exp_rd = (phase == 2) && (reads_issued < job_len) && (exp_q.size() + infl < DEPTH);
    check("read_o", read_o, exp_rd);
    check("tvalid", m_tvalid_o, exp_q.size() > 0);
    check("busy", busy_o, phase != 0);
    check("credit", (exp_q.size() + infl) <= DEPTH, 1);
    pop = (exp_q.size() > 0) && m_tready_i;
    exp_jd = 1'b0;
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check("tdata", m_tdata_o, hd[DW-1:0]);
      check("tlast", m_tlast_o, hd[DW]);
      if (pop) exp_jd = hd[DW];
    end else begin
      check("tlast_empty", m_tlast_o, 0);
    end
    check("job_done", job_done_o, exp_jd);
    if (job_done_o) jd_count++;

    idx = -1;
    if (read_o) begin
      if (rd_total == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_total++;
      if (reads_issued < MAXW) idx = reads_issued;
      reads_issued++;
    end
    if (pop) begin
      got_q.push_back(exp_q[0][DW-1:0]);
      void'(exp_q.pop_front());
    end
    if (head >= 0)
      exp_q.push_back({(head == job_len - 1) ? 1'b1 : 1'b0, job_words[head]});
    void'(dq.pop_front());
    dq.push_back(idx);

    case (phase)
      0: if (arm_i && len_i >= 1 && int'(len_i) <= MAXW) begin
           phase = 1;
           job_len = int'(len_i);
           reads_issued = 0;
           for (int k = 0; k < MAXW; k++)
             job_words[k] = (word_base >= 0) ? DW'(word_base + k) : $urandom();
         end
      1: if (done_flag_i) phase = 2;
      default: if (exp_jd) phase = 0;
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int base);
    rd_total = 0;
    jd_count = 0;
    first_rd_cyc = -1;
    last_rd_cyc = -1;
    got_q.delete();
    word_base = base;
    len_i = LW'(len);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((phase != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("timeout", n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", read_o, 0);
    check("rst_tvalid", m_tvalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_jd", job_done_o, 0);
    check("rst_tdata", m_tdata_o, 0);
    reset = 1'b0;

    // len 4, back-to-back reads, A0..A3
    tready_mode = 1;
    done_flag_i = 1'b1;
    start_job(4, 'hA0);
    run_until_idle(60);
    check("t2_reads", rd_total, 4);
    check("t2_span", last_rd_cyc - first_rd_cyc, 3);
    check("t2_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check("t2_word", got_q[k], 'hA0 + k);
    check("t2_jd", jd_count, 1);

    // done held low for 20 cycles
    done_flag_i = 1'b0;
    start_job(3, -1);
    repeat (20) step();
    check("t6_noread", rd_total, 0);
    done_flag_i = 1'b1;
    done_cyc = cyc;
    run_until_idle(60);
    check("t6_first", first_rd_cyc, done_cyc + 1);
    check("t6_reads", rd_total, 3);

    // zero / oversize length ignored, arm while busy ignored
    len_i = '0; arm_i = 1'b1; step(); arm_i = 1'b0; step();
    check("t4_len0_busy", busy_o, 0);
    len_i = LW'(17); arm_i = 1'b1; step(); arm_i = 1'b0; step();
    check("t4_len17_busy", busy_o, 0);
    done_flag_i = 1'b0;
    start_job(6, 'h100);
    repeat (3) step();
    len_i = LW'(2); arm_i = 1'b1; step(); arm_i = 1'b0;
    done_flag_i = 1'b1;
    run_until_idle(80);
    check("t4_reads", rd_total, 6);
    check("t4_count", got_q.size(), 6);
    check("t4_jd", jd_count, 1);

    // len 12 against a stalled consumer
    tready_mode = 0;
    start_job(12, 'h200);
    repeat (30) step();
    check("t3_stall_reads", rd_total, DEPTH);
    tready_mode = 1;
    run_until_idle(80);
    check("t3_reads", rd_total, 12);
    check("t3_count", got_q.size(), 12);
    for (int k = 0; k < 12 && k < got_q.size(); k++) check("t3_word", got_q[k], 'h200 + k);

    // reset in the middle of a drain
    tready_mode = 0;
    start_job(12, -1);
    repeat (4) step();
    check("t1_pre_busy", busy_o, 1);
    reset = 1'b1;
    #1;
    check("t1_read", read_o, 0);
    check("t1_tvalid", m_tvalid_o, 0);
    check("t1_busy", busy_o, 0);
    check("t1_jd", job_done_o, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tready_mode = 1;
    repeat (4) step();
    check("t1_after_busy", busy_o, 0);

    // random jobs, random ready, len 5 first
    for (int j = 0; j < 8; j++) begin
      len = (j == 0) ? 5 : $urandom_range(1, MAXW);
      tready_mode = 2;
      done_flag_i = 1'b0;
      start_job(len, -1);
      repeat ($urandom_range(0, 5)) step();
      done_flag_i = 1'b1;
      repeat (2) step();
      done_flag_i = 1'($urandom_range(0, 1));
      run_until_idle(400);
      check("t5_reads", rd_total, len);
      check("t5_count", got_q.size(), len);
      check("t5_jd", jd_count, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
